// File: rtl/pc_pkg.sv
// Shared types and encodings for the fetch-PC generator.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_BR   = 2'd1,
    ST_WAIT_XRET = 2'd2
  } state_e;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_U = 2'b00;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] INST_MRET  = 32'h3020_0073;
  localparam logic [31:0] INST_SRET  = 32'h1020_0073;
  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [31:0] INST_UNIMP = 32'hc000_1073;

endpackage

// File: rtl/pc_unit_trap_target_calc.sv
// Trap destination: picks M or S from delegation, then direct or vectored entry from tvec.
module trap_target_calc
  import pc_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            deleg_bit,
  input  logic [1:0]      priv,
  input  logic            trap_is_irq,
  input  logic [5:0]      trap_cause,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] stvec,
  output logic [XLEN-1:0] target_pc,
  output logic [1:0]      target_priv,
  output logic            target_s
);

  logic [XLEN-1:0] tvec;
  logic [XLEN-1:0] base;

  always_comb begin
    // A trap taken from M never drops into S, whatever the delegation bit says.
    target_s    = deleg_bit && (priv != PRIV_M);
    target_priv = target_s ? PRIV_S : PRIV_M;
    tvec        = target_s ? stvec : mtvec;
    base        = {tvec[XLEN-1:2], 2'b00};
    target_pc   = base;
    if ((tvec[1:0] == 2'b01) && trap_is_irq) begin
      target_pc = base + {{(XLEN-8){1'b0}}, trap_cause, 2'b00};
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-PC generator: holds on unresolved control flow, redirects on branch/trap/xRET.
//   state        | meaning
//   ST_RUN       | sequential fetch, pc advances by 4 unless stalled or held
//   ST_WAIT_BR   | jump/branch fetched, pc held until br_resolve
//   ST_WAIT_XRET | MRET/SRET fetched, pc held until xret_commit
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              HOLD_LIMIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [31:0]     inst,
  input  logic            inst_valid,
  input  logic            br_resolve,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_commit,
  input  logic            trap_is_irq,
  input  logic [5:0]      trap_cause,
  input  logic            xret_commit,
  input  logic            xret_is_sret,
  input  logic            deleg_bit,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] stvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] sepc,
  input  logic [1:0]      mpp,
  input  logic            spp,
  output logic [XLEN-1:0] pc,
  output logic [1:0]      priv,
  output logic            trap_to_s,
  output logic            hold_timeout
);

  localparam int              CW        = $clog2(HOLD_LIMIT + 1);
  localparam logic [CW-1:0]   HOLD_INIT = CW'(HOLD_LIMIT);
  localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'd4};

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      priv_q, priv_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic            trap_to_s_q, trap_to_s_d;
  logic            timeout_q, timeout_d;

  logic [XLEN-1:0] trap_pc;
  logic [1:0]      trap_priv;
  logic            trap_s;
  logic            redirect;
  logic            unused_low_bits;

  // IALIGN=32: the low two bits of redirect targets never reach the PC.
  assign unused_low_bits = ^{br_target[1:0], mepc[1:0], sepc[1:0]};

  trap_target_calc #(.XLEN(XLEN)) u_trap_calc (
    .deleg_bit   (deleg_bit),
    .priv        (priv_q),
    .trap_is_irq (trap_is_irq),
    .trap_cause  (trap_cause),
    .mtvec       (mtvec),
    .stvec       (stvec),
    .target_pc   (trap_pc),
    .target_priv (trap_priv),
    .target_s    (trap_s)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    priv_d      = priv_q;
    hold_d      = hold_q;
    trap_to_s_d = 1'b0;
    timeout_d   = timeout_q;
    redirect    = 1'b0;

    if (trap_commit) begin
      pc_d        = trap_pc;
      priv_d      = trap_priv;
      trap_to_s_d = trap_s;
      redirect    = 1'b1;
    end else if (xret_commit) begin
      if (xret_is_sret) begin
        pc_d   = {sepc[XLEN-1:2], 2'b00};
        priv_d = spp ? PRIV_S : PRIV_U;
      end else begin
        pc_d   = {mepc[XLEN-1:2], 2'b00};
        priv_d = mpp;
      end
      redirect = 1'b1;
    end else if (br_resolve && (state_q == ST_WAIT_BR)) begin
      pc_d     = {br_target[XLEN-1:2], 2'b00};
      redirect = 1'b1;
    end

    if (redirect) begin
      state_d = ST_RUN;
      hold_d  = HOLD_INIT;
    end else if (state_q == ST_RUN) begin
      if (!stall) begin
        if (inst_valid && (inst[6:0] inside {OP_JAL, OP_JALR, OP_BRANCH})) begin
          state_d = ST_WAIT_BR;
        end else if (inst_valid && ((inst == INST_MRET) || (inst == INST_SRET))) begin
          state_d = ST_WAIT_XRET;
        end else if (!(inst_valid && ((inst == INST_ECALL) || (inst == INST_UNIMP)))) begin
          pc_d = pc_q + PC_STEP;
        end
      end
    end else begin
      // Remaining-cycles down-counter; hitting zero flags the timeout but keeps waiting.
      if (hold_q != '0) hold_d = hold_q - 1'b1;
      if (hold_d == '0) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      priv_q      <= PRIV_M;
      hold_q      <= HOLD_INIT;
      trap_to_s_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      priv_q      <= priv_d;
      hold_q      <= hold_d;
      trap_to_s_q <= trap_to_s_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pc           = pc_q;
  assign priv         = priv_q;
  assign trap_to_s    = trap_to_s_q;
  assign hold_timeout = timeout_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios followed by randomized traffic.
module tb_pc_unit;

  localparam int HOLD = 15;

  logic        clk = 1'b0;
  logic        rst, stall, inst_valid, br_resolve, trap_commit, trap_is_irq;
  logic        xret_commit, xret_is_sret, deleg_bit, spp;
  logic [31:0] inst;
  logic [5:0]  trap_cause;
  logic [1:0]  mpp;
  logic [63:0] br_target, mtvec, stvec, mepc, sepc;
  logic [63:0] pc;
  logic [1:0]  priv;
  logic        trap_to_s, hold_timeout;

  always #5 clk = ~clk;

  pc_unit #(.XLEN(64), .RESET_PC(64'h0), .HOLD_LIMIT(HOLD)) dut (
    .clk(clk), .rst(rst), .stall(stall), .inst(inst), .inst_valid(inst_valid),
    .br_resolve(br_resolve), .br_target(br_target), .trap_commit(trap_commit),
    .trap_is_irq(trap_is_irq), .trap_cause(trap_cause), .xret_commit(xret_commit),
    .xret_is_sret(xret_is_sret), .deleg_bit(deleg_bit), .mtvec(mtvec), .stvec(stvec),
    .mepc(mepc), .sepc(sepc), .mpp(mpp), .spp(spp), .pc(pc), .priv(priv),
    .trap_to_s(trap_to_s), .hold_timeout(hold_timeout)
  );

  typedef struct {
    bit [63:0] pc;
    bit [1:0]  priv;
    bit        tts;
    bit        to;
    int        id;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   vec_id = 0;

  // Reference model: mode 0 = running, 1 = waiting on branch, 2 = waiting on xRET
  bit [63:0] m_pc;
  bit [1:0]  m_priv;
  int        m_mode, m_wait;
  bit        m_tts, m_to;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp, int id);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  function automatic bit [63:0] align4(bit [63:0] a);
    return a - (a % 4);
  endfunction

  task automatic model_step();
    bit        to_s;
    bit [63:0] tv;
    int        opc;
    if (rst) begin
      m_pc = 0; m_priv = 3; m_mode = 0; m_wait = 0; m_tts = 0; m_to = 0;
      return;
    end
    m_tts = 0;
    opc = int'(inst % 128);
    if (trap_commit) begin
      to_s   = deleg_bit && (m_priv != 3);
      tv     = to_s ? stvec : mtvec;
      m_pc   = ((tv % 4 == 1) && trap_is_irq) ? align4(tv) + 4 * trap_cause : align4(tv);
      m_priv = to_s ? 2'd1 : 2'd3;
      m_tts  = to_s;
      m_mode = 0; m_wait = 0;
    end else if (xret_commit) begin
      if (xret_is_sret) begin m_pc = align4(sepc); m_priv = spp ? 2'd1 : 2'd0; end
      else begin m_pc = align4(mepc); m_priv = mpp; end
      m_mode = 0; m_wait = 0;
    end else if (br_resolve && m_mode == 1) begin
      m_pc = align4(br_target);
      m_mode = 0; m_wait = 0;
    end else if (m_mode == 0) begin
      if (!stall) begin
        if (inst_valid && (opc == 'h6f || opc == 'h67 || opc == 'h63)) m_mode = 1;
        else if (inst_valid && (inst == 32'h30200073 || inst == 32'h10200073)) m_mode = 2;
        else if (!(inst_valid && (inst == 32'h00000073 || inst == 32'hc0001073))) m_pc = m_pc + 4;
      end
    end else begin
      if (m_wait < HOLD) m_wait++;
      if (m_wait >= HOLD) m_to = 1;
    end
  endtask

  task automatic cyc();
    model_step();
    sb.push_back('{pc: m_pc, priv: m_priv, tts: m_tts, to: m_to, id: vec_id});
    vec_id++;
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; stall = 0; inst = 32'h00000013; inst_valid = 1;
    br_resolve = 0; br_target = 0; trap_commit = 0; trap_is_irq = 0; trap_cause = 0;
    xret_commit = 0; xret_is_sret = 0; deleg_bit = 0;
  endtask

  // Monitor: pc/priv are presented every cycle, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc", pc, e.pc, e.id);
        check("priv", {62'd0, priv}, {62'd0, e.priv}, e.id);
        check("trap_to_s", {63'd0, trap_to_s}, {63'd0, e.tts}, e.id);
        check("hold_timeout", {63'd0, hold_timeout}, {63'd0, e.to}, e.id);
      end
    end
  end

  initial begin
    idle();
    mtvec = 64'h400; stvec = 64'h200; mepc = 0; sepc = 0; mpp = 2'b11; spp = 1'b0;
    rst = 1;
    cyc(); cyc();
    rst = 0;
    repeat (4) cyc();
    check("nop_seq_pc", pc, 64'h10, -1);

    inst = 32'h0000006f; cyc();
    inst_valid = 0; cyc(); cyc();
    check("jal_hold_pc", pc, 64'h10, -1);
    br_resolve = 1; br_target = 64'h80; cyc();
    check("jal_target_pc", pc, 64'h80, -1);

    idle(); inst = 32'h30200073; cyc();
    idle(); inst_valid = 0; mepc = 64'h3004; mpp = 2'b01; xret_commit = 1; cyc();
    check("mret_pc", pc, 64'h3004, -1);
    check("mret_priv", {62'd0, priv}, 64'd1, -1);

    idle(); inst = 32'h00000073; cyc();
    check("ecall_hold_pc", pc, 64'h3004, -1);
    trap_commit = 1; trap_cause = 9; deleg_bit = 1; cyc();
    check("strap_pc", pc, 64'h200, -1);
    check("strap_to_s", {63'd0, trap_to_s}, 64'd1, -1);
    deleg_bit = 0; cyc();
    deleg_bit = 1; cyc();
    check("mtrap_pc", pc, 64'h400, -1);
    check("mtrap_priv", {62'd0, priv}, 64'd3, -1);

    idle(); mtvec = 64'h101; trap_commit = 1; trap_is_irq = 1; trap_cause = 7; cyc();
    check("vec_irq_pc", pc, 64'h11C, -1);
    trap_is_irq = 0; cyc();
    check("vec_exc_pc", pc, 64'h100, -1);

    idle(); inst = 32'h00000063; cyc();
    idle(); inst_valid = 0;
    repeat (HOLD - 1) cyc();
    check("timeout_before", {63'd0, hold_timeout}, 64'd0, -1);
    cyc();
    check("timeout_at_limit", {63'd0, hold_timeout}, 64'd1, -1);
    cyc();
    trap_commit = 1; br_resolve = 1; br_target = 64'h999; cyc();
    check("trap_beats_br", pc, 64'h100, -1);

    idle(); inst = 32'h00000063; cyc();
    idle(); inst_valid = 0; cyc(); cyc();
    rst = 1; cyc();
    check("rst_wait_pc", pc, 64'h0, -1);
    check("rst_wait_to", {63'd0, hold_timeout}, 64'd0, -1);
    rst = 0;

    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      inst_valid   = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 8))
        0: inst = 32'h00000013;
        1: inst = 32'h0000006f;
        2: inst = 32'h00000067;
        3: inst = 32'h00000063;
        4: inst = 32'h30200073;
        5: inst = 32'h10200073;
        6: inst = 32'h00000073;
        7: inst = 32'hc0001073;
        default: inst = $urandom;
      endcase
      br_resolve   = ($urandom_range(0, 3) == 0);
      br_target    = {$urandom, $urandom};
      trap_commit  = ($urandom_range(0, 15) == 0);
      trap_is_irq  = $urandom_range(0, 1);
      trap_cause   = 6'($urandom_range(0, 63));
      xret_commit  = ($urandom_range(0, 9) == 0);
      xret_is_sret = $urandom_range(0, 1);
      deleg_bit    = $urandom_range(0, 1);
      mtvec        = {$urandom, $urandom};
      stvec        = {$urandom, $urandom};
      mepc         = {$urandom, $urandom};
      sepc         = {$urandom, $urandom};
      mpp          = 2'($urandom_range(0, 3));
      spp          = $urandom_range(0, 1);
      cyc();
    end

    idle(); cyc();
    @(negedge clk); @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
